// File: rtl/hist_pkg.sv
// Shared constants, state encoding and flat-vector helper for the histogram
// builder and the downstream derivative stage.
package hist_pkg;

    localparam int PIXEL_W = 8;
    localparam int COUNT_W = 16;
    localparam int BINS    = 1 << PIXEL_W;
    localparam int SIZE    = BINS * COUNT_W - 1;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_WAIT  = 1'b1
    } state_e;

    // LSB position of bin k inside the flat histogram vector.
    function automatic int flat_lsb(input int k);
        return k * COUNT_W;
    endfunction

endpackage

// File: rtl/hist_if.sv
// Pixel-in and histogram-out streams of the histogram builder.
// Both streams: a beat moves on a rising edge where valid && ready are both 1;
// the producer holds its payload stable while valid=1 and ready=0.
interface hist_if
    import hist_pkg::*;
();

    logic [PIXEL_W-1:0] i_pixel;
    logic               i_pixel_valid;
    logic               i_eof;
    logic               o_pixel_ready;
    logic [SIZE:0]      o_histogram_flat;
    logic               o_saturated;
    logic               o_valid;
    logic               i_ready;

    modport slave (
        input  i_pixel, i_pixel_valid, i_eof, i_ready,
        output o_pixel_ready, o_histogram_flat, o_saturated, o_valid
    );

    modport master (
        output i_pixel, i_pixel_valid, i_eof, i_ready,
        input  o_pixel_ready, o_histogram_flat, o_saturated, o_valid
    );

endinterface

// File: rtl/histogram_builder_bank.sv
// Bank of BINS saturating counters plus the frame saturation flag.
// flat_o/sat_o show the next-state view, so a load can include this edge's pixel.
module hist_bin_bank
    import hist_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               inc_i,
    input  logic [PIXEL_W-1:0] idx_i,
    input  logic               clr_i,
    output logic [SIZE:0]      flat_o,
    output logic               sat_o
);

    logic [COUNT_W-1:0] bins_q [BINS];
    logic [COUNT_W-1:0] bins_d [BINS];
    logic               sat_q;
    logic               sat_d;

    always_comb begin
        bins_d = bins_q;
        sat_d  = sat_q;
        if (inc_i) begin
            if (bins_q[idx_i] == COUNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                bins_d[idx_i] = bins_q[idx_i] + COUNT_ONE;
            end
        end
    end

    always_comb begin
        flat_o = '0;
        for (int k = 0; k < BINS; k++) begin
            flat_o[flat_lsb(k) +: COUNT_W] = bins_d[k];
        end
    end

    assign sat_o = sat_d;

    // Clear wins over the increment: the loading pixel is already in flat_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < BINS; k++) begin
                bins_q[k] <= '0;
            end
            sat_q <= 1'b0;
        end else if (clr_i) begin
            for (int k = 0; k < BINS; k++) begin
                bins_q[k] <= '0;
            end
            sat_q <= 1'b0;
        end else begin
            bins_q <= bins_d;
            sat_q  <= sat_d;
        end
    end

endmodule

// File: rtl/histogram_builder.sv
// Per-frame intensity histogram: accumulates pixels in the bin bank and hands
// each completed frame to a one-deep valid/ready output register.
module histogram_builder
    import hist_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_reset_n,
    hist_if.slave  bus,
    output state_e o_state_dbg
);

    state_e        state_q;
    logic          valid_q;
    logic          sat_q;
    logic [SIZE:0] flat_q;

    logic          accept;
    logic          out_free;
    logic          load;
    logic [SIZE:0] bank_flat;
    logic          bank_sat;

    assign accept   = bus.i_pixel_valid && (state_q == S_ACCUM);
    assign out_free = !valid_q || bus.i_ready;
    assign load     = out_free && ((state_q == S_WAIT) || (accept && bus.i_eof));

    hist_bin_bank u_bank (
        .clk_i   (i_clk),
        .rst_n_i (i_reset_n),
        .inc_i   (accept),
        .idx_i   (bus.i_pixel),
        .clr_i   (load),
        .flat_o  (bank_flat),
        .sat_o   (bank_sat)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_ACCUM;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            flat_q  <= '0;
        end else begin
            if (load) begin
                flat_q  <= bank_flat;
                sat_q   <= bank_sat;
                valid_q <= 1'b1;
            end else if (bus.i_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_ACCUM: if (accept && bus.i_eof && !out_free) state_q <= S_WAIT;
                S_WAIT:  if (out_free) state_q <= S_ACCUM;
                default: state_q <= S_ACCUM;
            endcase
        end
    end

    assign bus.o_pixel_ready    = (state_q == S_ACCUM);
    assign bus.o_histogram_flat = flat_q;
    assign bus.o_saturated      = sat_q;
    assign bus.o_valid          = valid_q;
    assign o_state_dbg          = state_q;

endmodule

// File: tb/tb_histogram_builder.sv
// Self-checking bench for histogram_builder: a reference histogram model feeds
// an expected-frame queue that is checked whenever the DUT hands a frame over.
module tb_histogram_builder;
    import hist_pkg::*;

    logic   i_clk;
    logic   i_reset_n;
    state_e dut_state;

    hist_if bus ();

    histogram_builder dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .bus         (bus),
        .o_state_dbg (dut_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    int            model_bins [BINS];
    logic          model_sat;
    logic [SIZE:0] exp_q [$];
    logic          exp_sat_q [$];

    function automatic logic [COUNT_W-1:0] out_bin(input int k);
        return bus.o_histogram_flat[k*COUNT_W +: COUNT_W];
    endfunction

    function automatic logic [SIZE:0] model_flat();
        logic [SIZE:0] f;
        f = '0;
        for (int k = 0; k < BINS; k++) f[k*COUNT_W +: COUNT_W] = COUNT_W'(model_bins[k]);
        return f;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < BINS; k++) model_bins[k] = 0;
        model_sat = 1'b0;
    endtask

    // Scoreboard: a frame transfers at the next rising edge when valid && ready.
    always @(negedge i_clk) begin
        if (i_reset_n && bus.o_valid && bus.i_ready) begin
            logic [SIZE:0] e_flat;
            logic          e_sat;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_frame: got a frame, queue empty");
            end else begin
                e_flat = exp_q.pop_front();
                e_sat  = exp_sat_q.pop_front();
                if (bus.o_histogram_flat !== e_flat || bus.o_saturated !== e_sat) begin
                    n_fail++;
                    for (int k = 0; k < BINS; k++) begin
                        if (out_bin(k) !== e_flat[k*COUNT_W +: COUNT_W]) begin
                            $display("FAIL sb_frame: bin %0d got %0d want %0d (sat got %0b want %0b)",
                                     k, out_bin(k), e_flat[k*COUNT_W +: COUNT_W], bus.o_saturated, e_sat);
                            break;
                        end
                    end
                    if (bus.o_histogram_flat === e_flat)
                        $display("FAIL sb_sat: got %0b want %0b", bus.o_saturated, e_sat);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_pixel(input logic [PIXEL_W-1:0] pix, input logic eof);
        bit accepted;
        bit done;
        done = 0;
        bus.i_pixel       = pix;
        bus.i_pixel_valid = 1'b1;
        bus.i_eof         = eof;
        for (int c = 0; c < 100 && !done; c++) begin
            accepted = bus.o_pixel_ready;
            @(posedge i_clk);
            if (accepted) begin
                done = 1;
                if (model_bins[pix] == 65535) model_sat = 1'b1;
                else model_bins[pix]++;
                if (eof) begin
                    exp_q.push_back(model_flat());
                    exp_sat_q.push_back(model_sat);
                    model_clear();
                end
            end
        end
        #1;
        bus.i_pixel_valid = 1'b0;
        bus.i_eof         = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: pixel %0d not accepted within 100 cycles", pix);
        end
    endtask

    task automatic drain(input int cycles);
        bus.i_ready = 1'b1;
        repeat (cycles) @(posedge i_clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_checks++;
        if (bus.o_histogram_flat !== '0) begin n_fail++; $display("FAIL reset_flat: got nonzero want 0"); end
        n_checks++;
        if (bus.o_saturated !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", bus.o_saturated); end
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (bus.o_pixel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.o_pixel_ready); end
    endtask

    task automatic test_basic();
        bus.i_ready = 1'b1;
        send_pixel(8'd3, 1'b0);
        send_pixel(8'd3, 1'b0);
        send_pixel(8'd7, 1'b1);
        n_checks++;
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid got %b want 1", bus.o_valid); end
        n_checks++;
        if (out_bin(3) !== 16'd2 || out_bin(7) !== 16'd1) begin
            n_fail++; $display("FAIL basic_bins: bin3 got %0d want 2, bin7 got %0d want 1", out_bin(3), out_bin(7));
        end
        n_checks++;
        if (bus.o_saturated !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b want 0", bus.o_saturated); end
        @(posedge i_clk);
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", bus.o_valid); end
    endtask

    task automatic test_backpressure();
        bus.i_ready = 1'b0;
        send_pixel(8'd5, 1'b1);
        n_checks++;
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_a_valid: got %b want 1", bus.o_valid); end
        send_pixel(8'd5, 1'b0);
        send_pixel(8'd5, 1'b1);
        n_checks++;
        if (bus.o_pixel_ready !== 1'b0 || dut_state !== S_WAIT) begin
            n_fail++; $display("FAIL bp_wait: ready got %b want 0, state got %0d want %0d", bus.o_pixel_ready, dut_state, S_WAIT);
        end
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++;
        if (out_bin(5) !== 16'd1 || bus.o_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: bin5 got %0d want 1, valid got %b want 1", out_bin(5), bus.o_valid);
        end
        bus.i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_ready = 1'b0;
        n_checks++;
        if (bus.o_valid !== 1'b1 || out_bin(5) !== 16'd2) begin
            n_fail++; $display("FAIL bp_reload: valid got %b want 1, bin5 got %0d want 2", bus.o_valid, out_bin(5));
        end
        n_checks++;
        if (bus.o_pixel_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", bus.o_pixel_ready); end
        drain(1);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: valid got %b want 0", bus.o_valid); end
    endtask

    task automatic test_saturation();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 65537; i++) send_pixel(8'd0, 1'b0);
        send_pixel(8'd1, 1'b1);
        n_checks++;
        if (out_bin(0) !== 16'hFFFF || out_bin(1) !== 16'd1 || bus.o_saturated !== 1'b1) begin
            n_fail++; $display("FAIL sat_frame: bin0 got %0d want 65535, bin1 got %0d want 1, sat got %b want 1",
                               out_bin(0), out_bin(1), bus.o_saturated);
        end
        send_pixel(8'd2, 1'b1);
        n_checks++;
        if (bus.o_saturated !== 1'b0 || out_bin(0) !== 16'd0 || out_bin(2) !== 16'd1) begin
            n_fail++; $display("FAIL sat_cleared: sat got %b want 0, bin0 got %0d want 0, bin2 got %0d want 1",
                               bus.o_saturated, out_bin(0), out_bin(2));
        end
        drain(2);
    endtask

    task automatic test_back_to_back();
        bus.i_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_pixel(8'd9, 1'b1);
            n_checks++;
            if (bus.o_valid !== 1'b1 || out_bin(9) !== 16'd1 || bus.o_pixel_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_frame%0d: valid %b bin9 %0d ready %b, want 1/1/1",
                                   f, bus.o_valid, out_bin(9), bus.o_pixel_ready);
            end
        end
        drain(2);
    endtask

    task automatic test_idle_gaps();
        bus.i_ready = 1'b1;
        send_pixel(8'd0, 1'b0);
        bus.i_pixel = 8'd77;
        bus.i_eof   = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_eof = 1'b0;
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL gap_eof_ignored: valid got %b want 0", bus.o_valid); end
        repeat ($urandom_range(1, 3)) @(posedge i_clk);
        #1;
        send_pixel(8'd255, 1'b1);
        n_checks++;
        if (out_bin(0) !== 16'd1 || out_bin(255) !== 16'd1 || out_bin(77) !== 16'd0) begin
            n_fail++; $display("FAIL gap_bins: bin0 %0d bin255 %0d bin77 %0d, want 1/1/0",
                               out_bin(0), out_bin(255), out_bin(77));
        end
        drain(2);
    endtask

    task automatic test_async_reset();
        bus.i_ready = 1'b0;
        send_pixel(8'd4, 1'b1);
        send_pixel(8'd6, 1'b1);
        n_checks++;
        if (dut_state !== S_WAIT) begin n_fail++; $display("FAIL ar_in_wait: state got %0d want %0d", dut_state, S_WAIT); end
        #2;
        i_reset_n = 1'b0;
        exp_q.delete();
        exp_sat_q.delete();
        model_clear();
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_histogram_flat !== '0 || dut_state !== S_ACCUM) begin
            n_fail++; $display("FAIL ar_immediate: valid %b flat_zero %b state %0d, want 0/1/%0d",
                               bus.o_valid, (bus.o_histogram_flat === '0), dut_state, S_ACCUM);
        end
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_checks++;
        if (bus.o_pixel_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", bus.o_pixel_ready); end
        bus.i_ready = 1'b1;
        send_pixel(8'd4, 1'b1);
        n_checks++;
        if (out_bin(4) !== 16'd1 || out_bin(6) !== 16'd0) begin
            n_fail++; $display("FAIL ar_new_frame: bin4 %0d bin6 %0d, want 1/0", out_bin(4), out_bin(6));
        end
        drain(2);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.i_pixel       = '0;
        bus.i_pixel_valid = 1'b0;
        bus.i_eof         = 1'b0;
        bus.i_ready       = 1'b1;
        model_clear();

        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_back_to_back();
        test_idle_gaps();
        test_async_reset();

        drain(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d frames never delivered, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_builder.md
Name: histogram_builder

Overview:
- Source end of the flat-histogram valid/ready stream that feeds the histogram derivative stage.
- Accepts a pixel intensity stream and accumulates per-intensity counts in a register bank.
- On end-of-frame, transfers the completed histogram into a one-deep output register, presents it as a flat vector with valid/ready, and clears the bank for the next frame.
- Sits between the sensor pixel path and histogram_derivative_wrapper.

Parameters:
- PIXEL_W, 8, pixel intensity width; BINS = 2**PIXEL_W (derived, 256 by default).
- COUNT_W, 16, width of each bin counter.
- SIZE, BINS*COUNT_W-1 (4095), MSB index of the flat output; must match the derivative stage's SIZE.

Ports:
- i_clk, input, 1, single clock; all state on rising edge.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_pixel, input, PIXEL_W, pixel intensity, used as the bin index.
- i_pixel_valid, input, 1, i_pixel/i_eof valid.
- i_eof, input, 1, qualifies the current pixel as the last pixel of the frame.
- o_pixel_ready, output, 1, block accepts a pixel this cycle.
- o_histogram_flat, output, SIZE+1, bin k at [k*COUNT_W +: COUNT_W].
- o_saturated, output, 1, some bin of the presented frame hit its maximum; qualified by o_valid.
- o_valid, output, 1, o_histogram_flat holds a complete frame.
- i_ready, input, 1, downstream consumes the frame when o_valid && i_ready.

Behaviour:
- Reset (async, i_reset_n=0): all bins 0; o_histogram_flat 0; o_valid 0; o_saturated 0; internal saturation flag 0; state S_ACCUM. o_pixel_ready therefore reads 1 once reset is released.
- Pixel accept: i_pixel_valid && o_pixel_ready. o_pixel_ready = (state == S_ACCUM). It is decoded from state only and never depends on i_pixel_valid, i_eof or i_ready.
- Increment: on accept, bin[i_pixel] += 1 at that edge.
  - A bin at 2**COUNT_W-1 holds its value (saturates) and sets the frame saturation flag.
  - Other bins are unchanged.
- Output handshake:
  - A frame transfers at an edge where o_valid && i_ready. o_valid falls after that edge unless a new frame loads at the same edge.
  - While o_valid=1 && i_ready=0, o_histogram_flat and o_saturated hold stable.
  - The output register is "free" when !o_valid || i_ready.
- State S_ACCUM, on accept with i_eof=1:
  - Output free: the load value is the bank including this pixel's increment. Load it into o_histogram_flat. o_saturated takes the flag including this pixel. o_valid becomes 1, the bank and flag clear, and the block stays in S_ACCUM. o_valid is visible the cycle after the eof edge (latency 1).
  - Output not free: apply the increment, then go to S_WAIT.
- State S_WAIT:
  - o_pixel_ready=0; no pixels are accepted.
  - On the first edge where the output is free: load the bank and flag into the output, set o_valid=1, clear the bank and flag, return to S_ACCUM.
  - A back-to-back drain and reload in the same edge is legal. o_valid stays 1 with the new data.
- Clearing: a cleared bank starts the next frame at 0. A pixel accepted on the cycle after a clear counts in the new frame only.
- i_eof with i_pixel_valid=0 is ignored.
- Empty frames do not exist: every frame ends with an accepted pixel carrying i_eof.
- Asserting reset mid-frame or mid-handshake discards both the bank and any pending output frame immediately; there is no partial emit.

Decomposition:
- Package hist_pkg holds:
  - PIXEL_W, COUNT_W, BINS and SIZE constants, shared with the derivative stage;
  - the state enum {S_ACCUM, S_WAIT};
  - a flat-index helper function for bin k.
- One sub-module, hist_bin_bank, holds the BINS saturating counters with increment and clear, plus the saturation flag.
- histogram_builder owns the FSM and the output register.

Test Plan:
- Reset, then frame of pixels 3,3,7 (eof on 7), i_ready=1 -> o_valid=1 one cycle after the eof edge; bin3=2, bin7=1, others 0; o_saturated=0; o_valid drops next cycle.
- Back-pressure: i_ready=0, frame A = {5}, then frame B = {5,5} with eof -> o_pixel_ready falls after B's eof; output holds A (bin5=1). Raise i_ready for one cycle -> output becomes B (bin5=2), o_valid stays 1, o_pixel_ready returns to 1.
- Saturation: 65537 pixels of value 0 then eof on 1 -> bin0=65535, bin1=1, o_saturated=1. Next frame {2} -> o_saturated=0.
- Back-to-back frames {9 eof},{9 eof},{9 eof} with i_ready=1 -> three output frames, each with bin9=1 and no accumulation carry-over; o_pixel_ready stays 1 throughout.
- Idle gaps: i_pixel_valid toggling 1/0 within a frame of {0,255} -> only valid beats count; bin0=1, bin255=1.
- Async reset asserted between edges while in S_WAIT -> o_valid=0 and output zero immediately. After release, o_pixel_ready=1 and a frame {4} yields bin4=1 only.
